ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 144 ++++++++++++++
 tb/tb_ex_mem_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with architectural flags, a retired-instruction
// counter and a halt sequencer (RUN -> DRAIN -> HALTED).
module ex_mem_reg #(
    parameter int DST_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [15:0]      ex_aluResult,
    input  logic [15:0]      ex_writeData,
    input  logic             ex_memRead,
    input  logic             ex_memWrite,
    input  logic             ex_regWrite,
    input  logic             ex_memToReg,
    input  logic             ex_sawBranch,
    input  logic             ex_setFlags,
    input  logic             ex_halt,
    input  logic [2:0]       ex_branchOp,
    input  logic [DST_W-1:0] ex_dst,
    input  logic             ex_N,
    input  logic             ex_Z,
    input  logic             ex_V,
    output logic [15:0]      address,
    output logic [15:0]      writeData,
    output logic             memRead,
    output logic             memWrite,
    output logic             regWrite,
    output logic             memToReg,
    output logic             sawBranch,
    output logic [2:0]       branchOp,
    output logic [DST_W-1:0] dst,
    output logic             valid,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             hlt,
    output logic [15:0]      retired
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic [15:0]      address;
        logic [15:0]      writeData;
        logic             memRead;
        logic             memWrite;
        logic             regWrite;
        logic             memToReg;
        logic             sawBranch;
        logic [2:0]       branchOp;
        logic [DST_W-1:0] dst;
    } memSlot_t;

    state_t   state, stateNext;
    logic [1:0] drainCnt, drainCntNext;
    memSlot_t slot, exSlot;

    always_comb begin
        exSlot.address   = ex_aluResult;
        exSlot.writeData = ex_writeData;
        exSlot.memRead   = ex_memRead;
        exSlot.memWrite  = ex_memWrite;
        exSlot.regWrite  = ex_regWrite;
        exSlot.memToReg  = ex_memToReg;
        exSlot.sawBranch = ex_sawBranch;
        exSlot.branchOp  = ex_branchOp;
        exSlot.dst       = ex_dst;
    end

    // Next-state logic; only consulted on non-stalled edges.
    always_comb begin
        stateNext    = state;
        drainCntNext = drainCnt;
        case (state)
            RUN: begin
                if (!flush && ex_valid && ex_halt) begin
                    stateNext    = DRAIN;
                    drainCntNext = 2'd2;
                end
            end
            DRAIN: begin
                if (drainCnt <= 2'd1) begin
                    stateNext    = HALTED;
                    drainCntNext = 2'd0;
                end else begin
                    drainCntNext = drainCnt - 2'd1;
                end
            end
            HALTED: stateNext = HALTED;
            default: begin
                stateNext    = RUN;
                drainCntNext = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            drainCnt <= 2'd0;
            slot     <= '0;
            valid    <= 1'b0;
            N        <= 1'b0;
            Z        <= 1'b0;
            V        <= 1'b0;
            retired  <= 16'h0000;
        end else if (!stall) begin
            state    <= stateNext;
            drainCnt <= drainCntNext;
            if (flush) begin
                slot  <= '0;
                valid <= 1'b0;
            end else if (state == RUN) begin
                slot  <= exSlot;
                valid <= ex_valid;
                if (ex_valid) begin
                    retired <= retired + 16'd1;
                    if (ex_setFlags) begin
                        N <= ex_N;
                        Z <= ex_Z;
                        V <= ex_V;
                    end
                end
            end else begin
                // Draining/halted: data held, nothing new enters MEM.
                valid <= 1'b0;
            end
        end
    end

    assign address   = slot.address;
    assign writeData = slot.writeData;
    assign branchOp  = slot.branchOp;
    assign dst       = slot.dst;
    assign memRead   = valid & slot.memRead;
    assign memWrite  = valid & slot.memWrite;
    assign regWrite  = valid & slot.regWrite;
    assign memToReg  = valid & slot.memToReg;
    assign sawBranch = valid & slot.sawBranch;
    assign hlt       = (state == HALTED);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: driver pushes model-predicted outputs,
// monitor pops and compares one entry per clock edge.
module tb_ex_mem_reg;

    typedef struct packed {
        logic        valid;
        logic [15:0] alu;
        logic [15:0] wd;
        logic        mr, mw, rw, m2r, sb, sf, halt;
        logic [2:0]  bop;
        logic [3:0]  dst;
        logic        n, z, v;
    } exIn_t;

    typedef struct packed {
        logic [15:0] address;
        logic [15:0] writeData;
        logic        memRead, memWrite, regWrite, memToReg, sawBranch;
        logic [2:0]  branchOp;
        logic [3:0]  dst;
        logic        valid, N, Z, V, hlt;
        logic [15:0] retired;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n, stall, flush;
    exIn_t drv;
    outs_t act;

    logic [15:0] address, writeData, retired;
    logic memRead, memWrite, regWrite, memToReg, sawBranch, valid, N, Z, V, hlt;
    logic [2:0] branchOp;
    logic [3:0] dst;

    ex_mem_reg #(.DST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(drv.valid), .ex_aluResult(drv.alu), .ex_writeData(drv.wd),
        .ex_memRead(drv.mr), .ex_memWrite(drv.mw), .ex_regWrite(drv.rw),
        .ex_memToReg(drv.m2r), .ex_sawBranch(drv.sb), .ex_setFlags(drv.sf),
        .ex_halt(drv.halt), .ex_branchOp(drv.bop), .ex_dst(drv.dst),
        .ex_N(drv.n), .ex_Z(drv.z), .ex_V(drv.v),
        .address(address), .writeData(writeData), .memRead(memRead),
        .memWrite(memWrite), .regWrite(regWrite), .memToReg(memToReg),
        .sawBranch(sawBranch), .branchOp(branchOp), .dst(dst), .valid(valid),
        .N(N), .Z(Z), .V(V), .hlt(hlt), .retired(retired)
    );

    always #5 clk = ~clk;

    assign act = '{address, writeData, memRead, memWrite, regWrite, memToReg,
                   sawBranch, branchOp, dst, valid, N, Z, V, hlt, retired};

    // Reference model: the instruction sitting in MEM, flags, count, halt progress.
    exIn_t       mInstr;
    logic [2:0]  mFlags;
    logic [15:0] mRetired;
    bit          mHaltSeen;
    int          mDrainLeft;

    outs_t expQ[$];
    string tagQ[$];
    int checks = 0;
    int errors = 0;

    function automatic outs_t predict();
        outs_t o;
        o.address   = mInstr.alu;
        o.writeData = mInstr.wd;
        o.memRead   = mInstr.mr & mInstr.valid;
        o.memWrite  = mInstr.mw & mInstr.valid;
        o.regWrite  = mInstr.rw & mInstr.valid;
        o.memToReg  = mInstr.m2r & mInstr.valid;
        o.sawBranch = mInstr.sb & mInstr.valid;
        o.branchOp  = mInstr.bop;
        o.dst       = mInstr.dst;
        o.valid     = mInstr.valid;
        {o.N, o.Z, o.V} = mFlags;
        o.hlt       = mHaltSeen && (mDrainLeft == 0);
        o.retired   = mRetired;
        return o;
    endfunction

    task automatic modelEdge(input logic r, input logic s, input logic f, input exIn_t in);
        bit running;
        if (!r) begin
            mInstr = '0; mFlags = '0; mRetired = '0; mHaltSeen = 0; mDrainLeft = 0;
        end else if (!s) begin
            running = !mHaltSeen;
            if (mHaltSeen && mDrainLeft > 0) mDrainLeft--;
            if (f) begin
                mInstr = '0;
            end else if (running) begin
                mInstr = in;
                if (in.valid) begin
                    mRetired = mRetired + 16'd1;
                    if (in.sf) mFlags = {in.n, in.z, in.v};
                    if (in.halt) begin
                        mHaltSeen = 1; mDrainLeft = 2;
                    end
                end
            end else begin
                mInstr.valid = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f, input exIn_t in, input string tag);
        @(negedge clk);
        rst_n = r; stall = s; flush = f; drv = in;
        modelEdge(r, s, f, in);
        expQ.push_back(predict());
        tagQ.push_back(tag);
    endtask

    function automatic exIn_t randIn(input int haltOdds);
        exIn_t t;
        t = exIn_t'({$urandom, $urandom, $urandom});
        t.valid = ($urandom_range(0, 9) != 0);
        t.halt  = ($urandom_range(0, haltOdds) == 0);
        return t;
    endfunction

    // Monitor: every edge with an outstanding prediction is compared.
    initial begin
        outs_t e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                t = tagQ.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (t=%0t)", t, act, e, $time);
                end
            end
        end
    end

    initial begin
        exIn_t t;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; drv = '0;
        step(0, 0, 0, '0, "reset");
        step(0, 1, 1, randIn(5), "reset_over_stall_flush");

        // Basic store accept
        t = '0; t.valid = 1; t.alu = 16'h1234; t.mw = 1; t.wd = 16'hBEEF;
        step(1, 0, 0, t, "accept_store");
        step(1, 0, 0, '0, "bubble_after_store");

        // Stall beats flush, then flush alone
        t = '0; t.valid = 1; t.alu = 16'h0040; t.mr = 1; t.rw = 1; t.dst = 4'h7;
        step(1, 0, 0, t, "load_accept");
        for (int i = 0; i < 3; i++) step(1, 1, 1, randIn(1000), "stall_flush_hold");
        step(1, 0, 1, randIn(1000), "flush_alone");

        // Flag hold behaviour
        t = '0; t.valid = 1; t.sf = 1; t.z = 1;
        step(1, 0, 0, t, "flags_set_z");
        t = '0; t.valid = 1; t.sf = 0; t.z = 0; t.sb = 1;
        step(1, 0, 0, t, "flags_nosetflags");
        t = '0; t.valid = 1; t.sf = 1; t.z = 0;
        step(1, 0, 1, t, "flags_flushed");
        step(1, 0, 0, '0, "flags_idle");

        // Halt with a stall inside DRAIN
        t = randIn(1000); t.valid = 1; t.halt = 1;
        step(1, 0, 0, t, "halt_accept");
        step(1, 1, 0, randIn(1000), "drain_stall");
        step(1, 0, 0, randIn(1000), "drain_1");
        step(1, 0, 0, randIn(1000), "drain_2_halted");
        for (int i = 0; i < 4; i++) begin
            t = randIn(1000); t.valid = 1;
            step(1, i[0], i[1], t, "halted_ignore");
        end

        // Reset mid-DRAIN
        step(0, 0, 0, '0, "reset2");
        t = randIn(1000); t.valid = 1; t.halt = 1;
        step(1, 0, 0, t, "halt_accept2");
        step(1, 0, 0, randIn(1000), "drain_mid");
        step(0, 1, 0, randIn(1000), "reset_mid_drain");
        t = randIn(1000); t.valid = 1; t.halt = 0;
        step(1, 0, 0, t, "accept_after_reset");

        // Counter wrap
        step(0, 0, 0, '0, "reset_wrap");
        for (int i = 0; i < 65536; i++) begin
            t = randIn(1000); t.valid = 1; t.halt = 0;
            step(1, 0, 0, t, (i < 65535) ? "wrap_fill" : "wrap_over");
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 80) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0), randIn(40), "random");
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
